// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit path.
//   - DATA_W               : serial payload width (one byte)
//   - DEFAULT_CLKS_PER_BIT : 100 MHz system clock / 115200 baud
//   - tx_state_e           : transmitter FSM encoding. PARITY is always
//                            enumerated so the encoding stays the same
//                            whether or not parity is built in.
//   - even_parity()        : XOR of the data bits.
package uart_pkg;

  localparam int DATA_W               = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_CLEANUP = 3'd5
  } tx_state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_unit_if.sv
// uart_tx_if
//   Byte-source side of the UART transmitter.
//   Signals:
//     i_TX_DV     source -> tx   start strobe
//     i_TX_Byte   source -> tx   byte to send
//     o_TX_Active tx -> source   high from start bit through stop bit
//     o_TX_Serial tx -> pin      serial line, idles high
//     o_TX_Done   tx -> source   one-cycle pulse after the stop bit
//     dbg_state   tx -> observer current FSM state (tx_state_e encoding)
//   Modports: master = byte source, slave = transmitter.
//
//   Handshake: i_TX_DV is a valid-only strobe with no ready. A byte is taken
//   only on an edge where i_TX_DV=1 and the transmitter is IDLE; at any other
//   time the strobe and byte are ignored. The source paces itself with
//   o_TX_Active / o_TX_Done. Holding i_TX_DV high sends frames back to back.
interface uart_tx_if;
  import uart_pkg::*;

  logic              i_TX_DV;
  logic [DATA_W-1:0] i_TX_Byte;
  logic              o_TX_Active;
  logic              o_TX_Serial;
  logic              o_TX_Done;
  logic [2:0]        dbg_state;

  modport master (
    output i_TX_DV,
    output i_TX_Byte,
    input  o_TX_Active,
    input  o_TX_Serial,
    input  o_TX_Done,
    input  dbg_state
  );

  modport slave (
    input  i_TX_DV,
    input  i_TX_Byte,
    output o_TX_Active,
    output o_TX_Serial,
    output o_TX_Done,
    output dbg_state
  );

endinterface

// File: rtl/uart_tx_unit_bit_timer.sv
// uart_bit_timer
//   Counts the cycles of one serial bit. The counter runs 0..CLKS_PER_BIT-1
//   and o_tick is high during the last cycle of each bit, so the FSM moves
//   to the next bit on the edge that ends the current one.
//   Ports:
//     i_Clock  in  system clock
//     i_Reset  in  synchronous active-high reset
//     i_clear  in  hold the counter at 0 (FSM outside a bit)
//     o_tick   out last cycle of the current bit
//   CLKS_PER_BIT must be >= 2.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int              CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_last;

  assign at_last = (cnt == LAST);
  assign o_tick  = at_last && !i_clear;

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_clear) begin
      cnt <= '0;
    end else if (at_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_unit.sv
// uart_tx_unit
//   Byte-wide UART transmitter, 8N1 by default: start bit, 8 data bits LSB
//   first, stop bit, each CLKS_PER_BIT clocks long. The serial line is
//   driven straight from a flop, so it never glitches.
//   Ports:
//     i_Clock  in  system clock, rising edge
//     i_Reset  in  synchronous active-high reset; aborts any frame without
//                  a done pulse
//     tx       uart_tx_if.slave (strobe/byte in, active/serial/done/state out)
//   Parameters:
//     CLKS_PER_BIT  clocks per serial bit, >= 2
//   Build option:
//     UART_TX_PARITY_EN  when defined, an even-parity bit follows the data
//                        bits (11-bit frame).
//   Frame timing with N = CLKS_PER_BIT and DV accepted at edge E0:
//     bit k is on the line for edges E0+kN .. E0+kN+N-1, done pulses at
//     E0+(bits)N, IDLE again at E0+(bits)N+1, next accept at +2.
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic    i_Clock,
  input  logic    i_Reset,
  uart_tx_if.slave tx
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_START   = ST_START;
  localparam logic [2:0] S_DATA    = ST_DATA;
  localparam logic [2:0] S_PARITY  = ST_PARITY;
  localparam logic [2:0] S_STOP    = ST_STOP;
  localparam logic [2:0] S_CLEANUP = ST_CLEANUP;

  logic [2:0]        state;
  logic [DATA_W-1:0] tx_byte;
  logic [2:0]        bit_idx;
  logic [2:0]        next_idx;
  logic              serial;
  logic              active;
  logic              done;
  logic              timer_clear;
  logic              bit_tick;

  // The timer sits at zero whenever no bit is being timed, so the first
  // bit after acceptance gets a full N cycles.
  assign timer_clear = (state == S_IDLE) || (state == S_CLEANUP);
  assign next_idx    = bit_idx + 3'd1;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_clear (timer_clear),
    .o_tick  (bit_tick)
  );

  // Serial/active/done are registered together with the state change,
  // so every output edge lines up with the bit boundary.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state   <= S_IDLE;
      tx_byte <= '0;
      bit_idx <= '0;
      serial  <= 1'b1;
      active  <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          serial <= 1'b1;
          active <= 1'b0;
          done   <= 1'b0;
          if (tx.i_TX_DV) begin
            tx_byte <= tx.i_TX_Byte;
            bit_idx <= '0;
            serial  <= 1'b0;
            active  <= 1'b1;
            state   <= S_START;
          end
        end

        S_START: begin
          if (bit_tick) begin
            bit_idx <= '0;
            serial  <= tx_byte[0];
            state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_tick) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              serial <= even_parity(tx_byte);
              state  <= S_PARITY;
`else
              serial <= 1'b1;
              state  <= S_STOP;
`endif
            end else begin
              bit_idx <= next_idx;
              serial  <= tx_byte[next_idx];
            end
          end
        end

        // Only reachable with parity built in.
        S_PARITY: begin
          if (bit_tick) begin
            serial <= 1'b1;
            state  <= S_STOP;
          end
        end

        S_STOP: begin
          if (bit_tick) begin
            active <= 1'b0;
            done   <= 1'b1;
            state  <= S_CLEANUP;
          end
        end

        S_CLEANUP: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          serial <= 1'b1;
          active <= 1'b0;
          done   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign tx.o_TX_Serial = serial;
  assign tx.o_TX_Active = active;
  assign tx.o_TX_Done   = done;
  assign tx.dbg_state   = state;

endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit
//   Directed bench for uart_tx_unit with CLKS_PER_BIT = 4. Expected serial
//   bits come from a per-frame queue built from the byte under test.
module tb_uart_tx_unit;
  import uart_pkg::*;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int PERIOD = FRAME_BITS * N + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_if tx_if ();

  uart_tx_unit #(
    .CLKS_PER_BIT (N)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .tx      (tx_if)
  );

  // scoreboard
  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [0:0] exp_q[$];
  bit         poke_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check({tag, "_serial"}, 32'(tx_if.o_TX_Serial), 32'd1);
      check({tag, "_active"}, 32'(tx_if.o_TX_Active), 32'd0);
      check({tag, "_done"},   32'(tx_if.o_TX_Done),   32'd0);
      step();
    end
  endtask

  task automatic load_frame(input logic [7:0] b);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^b);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Called while sampling just after the accepting edge E0. Returns while
  // sampling just after E0+FRAME_BITS*N, where done must be high.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [0:0] bit_v;
    load_frame(b);
    while (exp_q.size() > 0) begin
      bit_v = exp_q.pop_front();
      for (int c = 0; c < N; c++) begin
        check({tag, "_serial"}, 32'(tx_if.o_TX_Serial), 32'(bit_v));
        check({tag, "_active"}, 32'(tx_if.o_TX_Active), 32'd1);
        check({tag, "_done"},   32'(tx_if.o_TX_Done),   32'd0);
        if (poke_en) begin
          tx_if.i_TX_DV   = ~tx_if.i_TX_DV;
          tx_if.i_TX_Byte = tx_if.i_TX_Byte + 8'h3B;
        end
        step();
      end
    end
    check({tag, "_end_done"},   32'(tx_if.o_TX_Done),   32'd1);
    check({tag, "_end_active"}, 32'(tx_if.o_TX_Active), 32'd0);
    check({tag, "_end_serial"}, 32'(tx_if.o_TX_Serial), 32'd1);
  endtask

  task automatic send(input string tag, input logic [7:0] b);
    tx_if.i_TX_DV   = 1'b1;
    tx_if.i_TX_Byte = b;
    step();
    tx_if.i_TX_DV   = 1'b0;
    check_frame(tag, b);
    step();
    check({tag, "_cleanup_done"}, 32'(tx_if.o_TX_Done), 32'd0);
    step();
    check_idle({tag, "_after"}, 4);
  endtask

  int t1, t2;

  initial begin
    rst             = 1'b1;
    tx_if.i_TX_DV   = 1'b0;
    tx_if.i_TX_Byte = 8'h00;
    repeat (3) step();
    check("rst_state", 32'(tx_if.dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    // reset then idle
    check_idle("idle", 20);

    // single frame 0xA5: 0,1,0,1,0,0,1,0,1,1
    send("a5", 8'hA5);

    // DV held high: 0x00 then 0xFF back to back
    tx_if.i_TX_DV   = 1'b1;
    tx_if.i_TX_Byte = 8'h00;
    step();
    t1 = cyc;
    tx_if.i_TX_Byte = 8'hFF;
    check_frame("b2b0", 8'h00);
    step();
    check("b2b_cleanup_done", 32'(tx_if.o_TX_Done), 32'd0);
    step();
    t2 = cyc;
    check("b2b_period", 32'(t2 - t1), 32'(PERIOD));
    check_frame("b2b1", 8'hFF);
    tx_if.i_TX_DV = 1'b0;
    step();
    step();
    check_idle("b2b_after", 6);

    // DV pulses and byte changes mid-frame are ignored
    tx_if.i_TX_DV   = 1'b1;
    tx_if.i_TX_Byte = 8'hC3;
    step();
    poke_en = 1'b1;
    check_frame("poke", 8'hC3);
    poke_en       = 1'b0;
    tx_if.i_TX_DV = 1'b0;
    step();
    step();
    check_idle("poke_after", 10);

    // reset at E0+15 aborts the frame with no done pulse
    tx_if.i_TX_DV   = 1'b1;
    tx_if.i_TX_Byte = 8'h5A;
    step();
    tx_if.i_TX_DV = 1'b0;
    load_frame(8'h5A);
    for (int i = 0; i < 15; i++) begin
      check("abort_serial", 32'(tx_if.o_TX_Serial), 32'(exp_q[i / N]));
      check("abort_active", 32'(tx_if.o_TX_Active), 32'd1);
      if (i < 14) step();
    end
    exp_q.delete();
    rst = 1'b1;
    step();
    check("abort_rst_serial", 32'(tx_if.o_TX_Serial), 32'd1);
    check("abort_rst_active", 32'(tx_if.o_TX_Active), 32'd0);
    check("abort_rst_done",   32'(tx_if.o_TX_Done),   32'd0);
    check("abort_rst_state",  32'(tx_if.dbg_state),   32'(ST_IDLE));
    rst = 1'b0;
    step();
    check_idle("abort_quiet", 50);
    send("3c", 8'h3C);

`ifdef UART_TX_PARITY_EN
    // 0x07: three ones -> parity 1; 0x03: two ones -> parity 0
    send("par07", 8'h07);
    send("par03", 8'h03);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
